// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO execute-stage controller:
// the HI/LO-class operation encoding and the controller FSM states.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_DIV  = 3'd1,
        OP_DIVU = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } hilo_state_e;

endpackage

// File: rtl/hilo_div_ctrl.sv
// Execute-stage controller: issues DIV/DIVU to the multi-cycle divider,
// stalls the pipe while it runs, and owns the architectural HI/LO registers.
module hilo_div_ctrl
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        flush_i,
    input  logic        pipe_stall_i,
    output logic        stall_o,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic        div_annul_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    hilo_state_e state;
    logic [63:0] res_q;
    logic        is_div;

    always_comb begin
        is_div      = (op_i == OP_DIV) || (op_i == OP_DIVU);
        stall_o     = ((state == ST_IDLE) && op_valid_i && is_div && !flush_i)
                      || (state == ST_BUSY);
        div_annul_o = flush_i && (state == ST_BUSY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            res_q        <= '0;
            div_start_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            hi_o         <= '0;
            lo_o         <= '0;
        end else if (flush_i) begin
            state       <= ST_IDLE;
            div_start_o <= 1'b0;
            res_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid_i) begin
                        case (op_i)
                            OP_DIV, OP_DIVU: begin
                                div_op1_o    <= opdata1_i;
                                div_op2_o    <= opdata2_i;
                                div_signed_o <= (op_i == OP_DIV);
                                div_start_o  <= 1'b1;
                                state        <= ST_BUSY;
                            end
                            OP_MTHI: hi_o <= opdata1_i;
                            OP_MTLO: lo_o <= opdata1_i;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    if (div_ready_i) begin
                        res_q       <= div_result_i;
                        div_start_o <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The divider still shows ready here; it is deliberately ignored.
                    if (!pipe_stall_i) begin
                        hi_o  <= res_q[63:32];
                        lo_o  <= res_q[31:0];
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl with a behavioural divider model
// (ready 34 cycles after start, 3 cycles for a zero divisor).
module tb_hilo_div_ctrl;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid_i, flush_i, pipe_stall_i;
    logic [2:0]  op_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        stall_o, div_start_o, div_signed_o, div_annul_o;
    logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hilo_div_ctrl dut (
        .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .flush_i(flush_i),
        .pipe_stall_i(pipe_stall_i), .stall_o(stall_o), .div_start_o(div_start_o),
        .div_signed_o(div_signed_o), .div_annul_o(div_annul_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    // Divider model: holds ready in its end state until start drops.
    typedef enum logic [1:0] {D_FREE, D_RUN, D_END} dstate_e;
    dstate_e dst;
    int      dcnt;

    function automatic logic [63:0] div_calc(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dst <= D_FREE; dcnt <= 0; div_ready_i <= 1'b0; div_result_i <= '0;
        end else if (div_annul_o) begin
            dst <= D_FREE; div_ready_i <= 1'b0;
        end else begin
            case (dst)
                D_FREE: if (div_start_o) begin
                    dst          <= D_RUN;
                    dcnt         <= (div_op2_o == 32'd0) ? 2 : 33;
                    div_result_i <= div_calc(div_signed_o, div_op1_o, div_op2_o);
                end
                D_RUN: if (dcnt == 1) begin
                    dst <= D_END; div_ready_i <= 1'b1;
                end else dcnt <= dcnt - 1;
                default: if (!div_start_o) begin
                    dst <= D_FREE; div_ready_i <= 1'b0;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one op starting just after a rising edge; returns at the negedge
    // of the cycle after it retires, so HI/LO can be checked by the caller.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nst, output logic sg, output logic st1);
        bit done = 0;
        op_valid_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
        nst = 0; sg = 1'b0; st1 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 1) begin sg = div_signed_o; st1 = div_start_o; end
            if (!stall_o) begin done = 1; break; end
            nst++;
        end
        if (!done) check("stall_release_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        op_valid_i = 1'b0; op_i = OP_NOP;
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          stall;
        logic        sgn;
    } vec_t;

    vec_t vt[8];
    int   nst;
    logic sg, st1;

    initial begin
        vt[0] = '{OP_MTHI, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'h0,        0,  1'b0};
        vt[1] = '{OP_MTLO, 32'h0BADF00D, 32'd0, 32'hDEADBEEF, 32'h0BADF00D, 0,  1'b0};
        vt[2] = '{OP_DIVU, 32'd100,      32'd7, 32'd2,        32'd14,       36, 1'b0};
        vt[3] = '{OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 36, 1'b1};
        vt[4] = '{OP_DIV,  32'd5,        32'd0, 32'd0,        32'd0,        5,  1'b1};
        vt[5] = '{OP_DIVU, 32'd9,        32'd3, 32'd0,        32'd3,        36, 1'b0};
        vt[6] = '{OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'd1,        32'h7FFFFFFC, 36, 1'b0};
        vt[7] = '{OP_DIV,  32'hFFFFFFEC, 32'hFFFFFFFA, 32'hFFFFFFFE, 32'd3, 36, 1'b1};

        rst = 1'b0; op_valid_i = 1'b0; op_i = OP_NOP; opdata1_i = '0; opdata2_i = '0;
        flush_i = 1'b0; pipe_stall_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_hi", {32'd0, hi_o}, 64'd0);
        check("rst_lo", {32'd0, lo_o}, 64'd0);
        check("rst_ctl", {60'd0, div_start_o, div_signed_o, stall_o, div_annul_o}, 64'd0);
        check("rst_ops", {div_op1_o, div_op2_o}, 64'd0);
        @(posedge clk); #1;

        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, nst, sg, st1);
            check($sformatf("v%0d_hi", i), {32'd0, hi_o}, {32'd0, vt[i].hi});
            check($sformatf("v%0d_lo", i), {32'd0, lo_o}, {32'd0, vt[i].lo});
            check($sformatf("v%0d_stall_cycles", i), 64'(nst), 64'(vt[i].stall));
            if (vt[i].op == OP_DIV || vt[i].op == OP_DIVU) begin
                check($sformatf("v%0d_signed", i), {63'd0, sg}, {63'd0, vt[i].sgn});
                check($sformatf("v%0d_start_c1", i), {63'd0, st1}, 64'd1);
            end
            @(posedge clk); #1;
        end

        // Flush in BUSY at cycle 10: annul, back to IDLE, HI/LO untouched.
        run_op(OP_MTHI, 32'h1234, 32'd0, nst, sg, st1);
        @(posedge clk); #1;
        run_op(OP_MTLO, 32'h5678, 32'd0, nst, sg, st1);
        @(posedge clk); #1;
        op_valid_i = 1'b1; op_i = OP_DIVU; opdata1_i = 32'd50; opdata2_i = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        op_valid_i = 1'b0; op_i = OP_NOP; flush_i = 1'b1;
        @(negedge clk);
        check("flush_annul", {63'd0, div_annul_o}, 64'd1);
        @(posedge clk); #1 flush_i = 1'b0;
        @(negedge clk);
        check("flush_idle", {62'd0, stall_o, div_start_o}, 64'd0);
        check("flush_annul_drop", {63'd0, div_annul_o}, 64'd0);
        repeat (40) @(negedge clk);
        check("flush_keep_hilo", {hi_o, lo_o}, {32'h1234, 32'h5678});
        @(posedge clk); #1;

        // Flush while a DIV is presented in IDLE: no stall, no start.
        op_valid_i = 1'b1; op_i = OP_DIVU; opdata1_i = 32'd7; opdata2_i = 32'd1; flush_i = 1'b1;
        @(negedge clk);
        check("flush_idle_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1 flush_i = 1'b0; op_valid_i = 1'b0; op_i = OP_NOP;
        @(negedge clk);
        check("flush_idle_nostart", {63'd0, div_start_o}, 64'd0);
        @(posedge clk); #1;
        run_op(OP_DIVU, 32'd8, 32'd2, nst, sg, st1);
        check("after_flush_div", {hi_o, lo_o}, {32'd0, 32'd4});
        @(posedge clk); #1;

        // pipe_stall held in DONE for 3 cycles: no commit, no restart.
        pipe_stall_i = 1'b1;
        op_valid_i = 1'b1; op_i = OP_DIVU; opdata1_i = 32'd20; opdata2_i = 32'd6;
        nst = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stall_o) break;
            nst++;
        end
        check("ps_stall_cycles", 64'(nst), 64'd36);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("ps_hold%0d_ctl", k), {62'd0, div_start_o, stall_o}, 64'd0);
            check($sformatf("ps_hold%0d_hilo", k), {hi_o, lo_o}, {32'd0, 32'd4});
            @(posedge clk); #1;
        end
        pipe_stall_i = 1'b0;
        @(negedge clk);
        check("ps_release_pre", {hi_o, lo_o}, {32'd0, 32'd4});
        @(posedge clk); #1 op_valid_i = 1'b0; op_i = OP_NOP;
        @(negedge clk);
        check("ps_commit", {hi_o, lo_o}, {32'd2, 32'd3});
        check("ps_no_restart", {63'd0, div_start_o}, 64'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a division.
        op_valid_i = 1'b1; op_i = OP_DIVU; opdata1_i = 32'd77; opdata2_i = 32'd5;
        repeat (5) begin @(posedge clk); #1; end
        op_valid_i = 1'b0; op_i = OP_NOP;
        #1 rst = 1'b0;
        #1;
        check("arst_hilo", {hi_o, lo_o}, 64'd0);
        check("arst_ops", {div_op1_o, div_op2_o}, 64'd0);
        check("arst_ctl", {61'd0, div_start_o, div_signed_o, stall_o}, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        run_op(OP_DIVU, 32'd1, 32'd1, nst, sg, st1);
        check("arst_after_div", {hi_o, lo_o}, {32'd0, 32'd1});
        check("arst_after_stall", 64'(nst), 64'd36);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Execute-stage controller that sits directly upstream of the multi-cycle divider and downstream of decode. It issues DIV/DIVU operations to the divider through its start/annul/ready handshake, stalls the pipeline while a division runs, and owns the architectural HI/LO registers. It writes those registers from the divider result or from MTHI/MTLO, and discards in-flight work on a pipeline flush.

## Interface
- No parameters; data width is fixed at 32.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- op_valid_i  in  1  valid HI/LO-class instruction presented this cycle.
- op_i  in  3  operation code from the shared package: NOP, DIV, DIVU, MTHI, MTLO.
- opdata1_i  in  32  rs value (dividend, or MTHI/MTLO source).
- opdata2_i  in  32  rt value (divisor).
- flush_i  in  1  pipeline flush; kills the presented or in-flight operation.
- pipe_stall_i  in  1  stall from later stages; the execute instruction cannot retire.
- stall_o  out  1  request to hold the execute stage.
- div_start_o  out  1  divider start, registered.
- div_signed_o  out  1  1 for DIV, 0 for DIVU, registered.
- div_annul_o  out  1  divider annul, combinational.
- div_op1_o, div_op2_o  out  32 each  latched operands, registered.
- div_result_i  in  64  {remainder, quotient} from the divider.
- div_ready_i  in  1  divider result valid.
- hi_o, lo_o  out  32 each  architectural HI and LO.

## Operation
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE. Every registered output and all internal registers clear to 0, including hi_o, lo_o, div_start_o, div_signed_o, div_op1_o, div_op2_o and the result holding register res_q.
- flush_i has highest priority in every state:
  - State goes to IDLE and div_start_o goes to 0.
  - res_q is discarded; HI/LO are not written.
- IDLE:
  - On op_valid_i with op DIV or DIVU (and no flush), latch opdata1_i/opdata2_i into div_op1_o/div_op2_o and set div_signed_o.
  - At the same edge, set div_start_o=1 and go to BUSY.
  - On op_valid_i with MTHI or MTLO, write opdata1_i into hi_o or lo_o at the edge. Rewrites while pipe_stall_i holds the instruction are idempotent.
- BUSY:
  - div_start_o stays 1.
  - When div_ready_i=1: capture div_result_i into res_q, drop div_start_o, go to DONE.
- DONE:
  - If pipe_stall_i=0: hi_o<=res_q[63:32], lo_o<=res_q[31:0], go to IDLE.
  - Otherwise wait in DONE. The re-presented DIV is not reissued.
- div_ready_i is ignored outside BUSY. This masks the stale ready the divider holds in its end state.
- Registered start guarantees at least one start-low cycle between consecutive divisions, so the divider always returns to free before a new start.
- The divider result is committed as-is. A zero divisor yields HI=0, LO=0.

## Timing
- stall_o = (IDLE && op_valid_i && op is DIV/DIVU && !flush_i) || BUSY.
- stall_o is low in DONE, so the DIV retires at the DONE edge unless pipe_stall_i is high.
- div_annul_o = flush_i && BUSY.
- Latency for a nonzero divisor, with the DIV presented in cycle 0:
  - Cycle 1: div_start_o high.
  - Cycle 35: div_ready_i seen.
  - Cycle 36: DONE.
  - Edge ending cycle 36: HI/LO updated.
- Latency for a zero divisor: div_ready_i arrives in cycle 4 and HI/LO update at the end of cycle 5.
- Flush in BUSY: annul is asserted that cycle, IDLE follows the next cycle, and a new DIV may then be accepted immediately.
- Flush coincident with div_ready_i: the flush wins and res_q is not captured.
- MTHI/MTLO has zero stall; its value is visible on hi_o/lo_o in the following cycle.

## Structure
- Shared package hilo_pkg holds:
  - the op_i encoding (NOP=0, DIV=1, DIVU=2, MTHI=3, MTLO=4);
  - the FSM state enum.
- Single flat module with no sub-module. The divider is a sibling instance wired at the execute-stage level.

## Test plan
- DIVU 100/7, no flush, pipe_stall_i=0 -> stall_o high for cycles 0–35; hi_o=2, lo_o=14 from cycle 37.
- DIV 0xFFFFFFF9 (−7) / 2 -> div_signed_o=1; lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIV 5/0 -> HI=0, LO=0 committed after 5 cycles. A back-to-back DIVU 9/3 then yields lo_o=3, hi_o=0, with no stale-ready capture.
- DIVU started, flush_i pulsed in cycle 10 -> div_annul_o=1 in cycle 10; HI/LO keep the prior MTHI 0x1234 / MTLO 0x5678 values; the next DIVU 8/2 gives lo_o=4.
- DIVU 20/6 with pipe_stall_i high for 3 cycles after ready -> state holds in DONE with div_start_o=0 and no restart; HI=2, LO=3 written only when pipe_stall_i falls.
- Assert rst mid-BUSY -> all outputs 0 immediately; after release, DIVU 1/1 gives lo_o=1, hi_o=0.
